// File: rtl/sipo_rx_ctrl_pkg.sv
// sipo_rx_ctrl_pkg
//   Shared types for the serial-in/parallel-out frame controller.
//   t_rx_state   : controller state encoding
//   count_width  : width of a counter that must hold 0..bits
package sipo_rx_ctrl_pkg;

    typedef enum bit [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } t_rx_state;

    function automatic int count_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/sipo_rx_ctrl_en.sv
// sipo_en
//   Enabled shift register used by sipo_rx_ctrl to assemble a word.
//   in_clk       : clock, rising edge
//   in_rst       : asynchronous active-low reset
//   in_enable    : shift in_serial in this cycle
//   in_clear     : synchronous clear, has priority over in_enable
//   in_serial    : serial data bit
//   out_parallel : current register contents
//   SHIFT_RIGHT=1 enters bits at the MSB (first bit ends at bit 0),
//   SHIFT_RIGHT=0 enters bits at bit 0 (first bit ends at the MSB).
module sipo_en #(
    parameter int BITS        = 8,
    parameter int SHIFT_RIGHT = 1
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_enable,
    input  logic            in_clear,
    input  logic            in_serial,
    output logic [BITS-1:0] out_parallel
);

    logic [BITS-1:0] shift_q;
    logic [BITS-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (in_clear) begin
            shift_d = '0;
        end else if (in_enable) begin
            if (SHIFT_RIGHT != 0) begin
                shift_d = {in_serial, shift_q[BITS-1:1]};
            end else begin
                shift_d = {shift_q[BITS-2:0], in_serial};
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out_parallel = shift_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl
//   Frame controller: sequences sipo_en to deserialise BITS-wide words
//   from a strobed serial stream, with a valid/ready holding register
//   and a sticky overrun flag.
//   in_clk / in_rst         : clock, asynchronous active-low reset
//   in_start                : begin a frame (Idle only)
//   in_bit_valid, in_serial : qualified serial bit
//   in_ready                : consumer accepts out_data
//   in_clear                : clears out_overrun
//   out_busy, out_bit_count : frame status
//   out_data, out_valid     : held word and its valid flag
//   out_overrun             : sticky, a completed word was dropped
//   out_parity_err          : only with SIPO_RX_CTRL_PARITY_EN defined
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | waiting for in_start, bit strobes ignored
//   ST_SHIFT  | collecting data bits
//   ST_PARITY | waiting for the even-parity bit (parity build)
module sipo_rx_ctrl
    import sipo_rx_ctrl_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int SHIFT_RIGHT = 1
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_start,
    input  logic                     in_bit_valid,
    input  logic                     in_serial,
    input  logic                     in_ready,
    input  logic                     in_clear,
    output logic                     out_busy,
    output logic [$clog2(BITS+1)-1:0] out_bit_count,
    output logic [BITS-1:0]          out_data,
    output logic                     out_valid,
`ifdef SIPO_RX_CTRL_PARITY_EN
    output logic                     out_parity_err,
`endif
    output logic                     out_overrun
);

    localparam int CW = count_width(BITS);

    t_rx_state       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic [BITS-1:0] par;
    logic [BITS-1:0] word_new;
    logic            sh_en, sh_clr, last_bit, word_done, load, drop;

    sipo_en #(.BITS(BITS), .SHIFT_RIGHT(SHIFT_RIGHT)) u_sipo (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_enable    (sh_en),
        .in_clear     (sh_clr),
        .in_serial    (in_serial),
        .out_parallel (par)
    );

    assign last_bit = (cnt_q == CW'(BITS - 1));

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (in_start) state_d = ST_SHIFT;
`ifdef SIPO_RX_CTRL_PARITY_EN
            ST_SHIFT:  if (in_bit_valid && last_bit) state_d = ST_PARITY;
            ST_PARITY: if (in_bit_valid) state_d = ST_IDLE;
`else
            ST_SHIFT:  if (in_bit_valid && last_bit) state_d = ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // The word is captured on the same edge as its final bit, so the
    // completed value is formed here rather than read from the register.
    always_comb begin
        sh_en  = (state_q == ST_SHIFT) && in_bit_valid;
        sh_clr = (state_q == ST_IDLE) && in_start;
`ifdef SIPO_RX_CTRL_PARITY_EN
        word_done = (state_q == ST_PARITY) && in_bit_valid;
        word_new  = par;
`else
        word_done = sh_en && last_bit;
        if (SHIFT_RIGHT != 0) begin
            word_new = {in_serial, par[BITS-1:1]};
        end else begin
            word_new = {par[BITS-2:0], in_serial};
        end
`endif
        load = word_done && (!valid_q || in_ready);
        drop = word_done && valid_q && !in_ready;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (in_bit_valid) begin
            cnt_d = (state_d == ST_IDLE) ? '0 : cnt_q + CW'(1);
        end
        data_d  = load ? word_new : data_q;
        valid_d = load ? 1'b1 : (valid_q && !in_ready);
        // set wins over clear
        ovr_d   = drop || (ovr_q && !in_clear);
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SIPO_RX_CTRL_PARITY_EN
    logic perr_q, perr_d;

    assign perr_d = load ? ((^par) ^ in_serial) : perr_q;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign out_parity_err = perr_q;
`endif

    assign out_busy      = (state_q != ST_IDLE);
    assign out_bit_count = cnt_q;
    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign out_overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
module tb_sipo_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, bit_valid, serial, ready, clear;
    logic       busy0, valid0, ovr0, busy1, valid1, ovr1;
    logic [3:0] cnt0, cnt1;
    logic [7:0] data0, data1;
`ifdef SIPO_RX_CTRL_PARITY_EN
    logic       perr0, perr1;
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    sipo_rx_ctrl #(.BITS(8), .SHIFT_RIGHT(1)) dut0 (
        .in_clk(clk), .in_rst(rst_n), .in_start(start), .in_bit_valid(bit_valid),
        .in_serial(serial), .in_ready(ready), .in_clear(clear),
        .out_busy(busy0), .out_bit_count(cnt0), .out_data(data0), .out_valid(valid0),
`ifdef SIPO_RX_CTRL_PARITY_EN
        .out_parity_err(perr0),
`endif
        .out_overrun(ovr0)
    );

    sipo_rx_ctrl #(.BITS(8), .SHIFT_RIGHT(0)) dut1 (
        .in_clk(clk), .in_rst(rst_n), .in_start(start), .in_bit_valid(bit_valid),
        .in_serial(serial), .in_ready(ready), .in_clear(clear),
        .out_busy(busy1), .out_bit_count(cnt1), .out_data(data1), .out_valid(valid1),
`ifdef SIPO_RX_CTRL_PARITY_EN
        .out_parity_err(perr1),
`endif
        .out_overrun(ovr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bits go out LSB of w first; in the parity build bit p follows.
    // hold_last leaves the final bit driven without clocking it in.
    task automatic send_frame(input logic [7:0] w, input logic p, input int gap,
                              input bit hold_last);
        logic [8:0] bv;
        bv = {p, w};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cnt_after_start", 32'(cnt0), 0);
        for (int i = 0; i < NB; i++) begin
            bit_valid = 1'b1;
            serial    = bv[i];
            if (i == NB - 1 && hold_last) return;
            tick();
            bit_valid = 1'b0;
            if (i < NB - 1) begin
                chk("cnt_strobe", 32'(cnt0), 32'(i + 1));
                for (int g = 0; g < gap; g++) begin
                    serial = ~serial;
                    tick();
                    chk("cnt_gap", 32'(cnt0), 32'(i + 1));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; serial = 1'b0;
        ready = 1'b1; clear = 1'b0;
        #23;
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_data", 32'(data0), 0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_ovr", 32'(ovr0), 0);
        rst_n = 1'b1;
        tick();

        // strobes in Idle are ignored
        bit_valid = 1'b1; serial = 1'b1;
        tick();
        chk("idle_bit_busy", 32'(busy0), 0);
        chk("idle_bit_cnt", 32'(cnt0), 0);
        bit_valid = 1'b0;

        // basic frame, latency exactly one cycle after the 8th bit
        send_frame(8'h49, 1'b1, 0, 1'b1);
        chk("basic_pre_valid", 32'(valid0), 0);
        chk("basic_pre_busy", 32'(busy0), 1);
        tick();
        bit_valid = 1'b0;
        chk("basic_valid", 32'(valid0), 1);
        chk("basic_data_lsb", 32'(data0), 32'h49);
        chk("basic_data_msb", 32'(data1), 32'h92);
        chk("basic_busy", 32'(busy0), 0);
        chk("basic_cnt", 32'(cnt0), 0);
        tick();
        chk("basic_consumed", 32'(valid0), 0);

        // gapped strobes with serial toggling between them
        send_frame(8'h49, 1'b1, 2, 1'b0);
        chk("gap_valid", 32'(valid0), 1);
        chk("gap_data", 32'(data0), 32'h49);
        tick();

        // start and strobe together: bit not sampled
        start = 1'b1; bit_valid = 1'b1; serial = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0;
        chk("start_strobe_busy", 32'(busy0), 1);
        chk("start_strobe_cnt", 32'(cnt0), 0);

        // reset mid-frame
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; serial = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        chk("mid_cnt", 32'(cnt0), 3);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy0), 0);
        chk("mrst_cnt", 32'(cnt0), 0);
        chk("mrst_data", 32'(data0), 0);
        chk("mrst_valid", 32'(valid0), 0);
        chk("mrst_ovr", 32'(ovr0), 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        chk("post_rst_data", 32'(data0), 32'hA5);
        chk("post_rst_data_msb", 32'(data1), 32'hA5);
        chk("post_rst_valid", 32'(valid0), 1);
        tick();

        // backpressure and overrun
        ready = 1'b0;
        send_frame(8'h49, 1'b1, 0, 1'b0);
        chk("bp_first_valid", 32'(valid0), 1);
        chk("bp_first_ovr", 32'(ovr0), 0);
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        chk("bp_data_kept", 32'(data0), 32'h49);
        chk("bp_ovr", 32'(ovr0), 1);
        chk("bp_valid", 32'(valid0), 1);
        tick();
        chk("bp_ovr_sticky", 32'(ovr0), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("bp_clear", 32'(ovr0), 0);
        chk("bp_valid_after_clr", 32'(valid0), 1);
        ready = 1'b1;
        tick();
        chk("bp_consumed", 32'(valid0), 0);

        // consume and complete on the same edge
        ready = 1'b0;
        send_frame(8'h49, 1'b1, 0, 1'b0);
        chk("sim_held", 32'(data0), 32'h49);
        send_frame(8'hA5, 1'b0, 0, 1'b1);
        ready = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk("sim_data", 32'(data0), 32'hA5);
        chk("sim_valid", 32'(valid0), 1);
        chk("sim_ovr", 32'(ovr0), 0);
        tick();
        chk("sim_consumed", 32'(valid0), 0);

        // clear and overrun together: set wins
        ready = 1'b0;
        send_frame(8'h49, 1'b1, 0, 1'b0);
        send_frame(8'hA5, 1'b0, 0, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0; bit_valid = 1'b0;
        chk("set_wins_ovr", 32'(ovr0), 1);
        chk("set_wins_data", 32'(data0), 32'h49);
        ready = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;

`ifdef SIPO_RX_CTRL_PARITY_EN
        send_frame(8'h49, 1'b1, 0, 1'b1);
        chk("par_cnt", 32'(cnt0), 8);
        chk("par_pre_valid", 32'(valid0), 0);
        tick();
        bit_valid = 1'b0;
        chk("par_ok_valid", 32'(valid0), 1);
        chk("par_ok_err", 32'(perr0), 0);
        chk("par_ok_data", 32'(data0), 32'h49);
        tick();
        send_frame(8'h49, 1'b0, 0, 1'b1);
        chk("par_bad_pre_valid", 32'(valid0), 0);
        tick();
        bit_valid = 1'b0;
        chk("par_bad_valid", 32'(valid0), 1);
        chk("par_bad_err", 32'(perr0), 1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Frame controller that sequences a serial-in/parallel-out shift register to deserialise fixed-width words from a bit-strobed serial stream.
- Sits between a bit-timing source (baud/strobe generator) and a word consumer. Provides start-of-frame sequencing, bit counting, an output holding register with valid/ready handshake, and overrun detection.

Parameters:
- BITS, 8: data bits per frame; must be >= 2.
- SHIFT_RIGHT, 1:
  - 1: new bit enters at the MSB, so the first-received bit ends at bit 0 (LSB-first).
  - 0: new bit enters at bit 0, so the first-received bit ends at the MSB.

Ports:
- in_clk  in  1  system clock, all logic on rising edge.
- in_rst  in  1  reset, asynchronous, active-low.
- in_start  in  1  begin a frame; honoured only in Idle.
- in_bit_valid  in  1  qualifies in_serial for one cycle.
- in_serial  in  1  serial data bit.
- in_ready  in  1  consumer accepts out_data when out_valid=1.
- in_clear  in  1  synchronous clear of out_overrun.
- out_busy  out  1  frame in progress (state != Idle).
- out_bit_count  out  $clog2(BITS+1)  qualified bits received in the current frame.
- out_data  out  BITS  held word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_overrun  out  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (in_rst=0, asynchronous): state Idle; shift register, out_data, out_bit_count, out_valid, out_overrun and out_busy are all 0. A reset mid-frame discards the partial word.
- States (enum):
  - Idle -> Shift on in_start; shift register and count cleared on entry.
  - Shift -> Idle when a qualified bit arrives with count = BITS-1.
  - With SIPO_RX_CTRL_PARITY_EN: Shift -> Parity instead, and Parity -> Idle on the next qualified bit.
- Shifting:
  - In Shift, each cycle with in_bit_valid=1 shifts in_serial in and increments the count.
  - Cycles without in_bit_valid hold all state; gaps are unbounded.
- Ignored inputs:
  - in_bit_valid in Idle.
  - in_start outside Idle.
  - in_start and in_bit_valid together in Idle: the frame starts, and that bit is not sampled.
- Completion:
  - In the cycle after the final qualified bit, out_data holds the assembled word and out_valid=1. Latency is 1 cycle.
  - The controller is back in Idle in that same cycle and can accept in_start immediately, giving double buffering.
- Handshake:
  - A word is consumed on a rising edge with out_valid & in_ready.
  - out_valid then drops to 0, unless a new word completes in the same edge. In that case the new word loads, out_valid stays 1 and no overrun occurs.
- Overrun:
  - A word completing while out_valid=1 and in_ready=0 is dropped; out_data is retained and out_overrun is set to 1.
  - out_overrun remains set until in_clear or reset. If in_clear and a new overrun occur in the same cycle, the set wins.
- out_bit_count:
  - 0 in Idle.
  - Counts 0..BITS during Shift and Parity; it reaches BITS only in Parity.

Optional Feature:
- Macro: SIPO_RX_CTRL_PARITY_EN.
- Defined:
  - After BITS data bits, one further qualified bit is taken as an even-parity bit.
  - Adds port out_parity_err (out, 1), registered alongside out_data, updated only when a word loads, reset 0.
  - out_parity_err = XOR of the data bits and the parity bit.
  - Completion latency is measured from the parity bit.
- Undefined: no Parity state, no out_parity_err port; the frame ends after BITS bits.

Decomposition:
- Package sipo_rx_ctrl_pkg holds the state enum t_rx_state (bit [1:0]: Idle, Shift, Parity) and any shared count-width helper.
- Sub-module sipo_en: a shift register with in_clk, in_rst, in_enable, in_clear, in_serial, out_parallel and parameters BITS and SHIFT_RIGHT. The controller drives its enable and clear.

Test Plan:
- Basic frame, BITS=8, SHIFT_RIGHT=1:
  - Stimulus: in_start, then bits 1,0,0,1,0,0,1,0 on consecutive strobes, in_ready=1.
  - Required: out_data=0x49 and out_valid=1 exactly one cycle after the 8th bit.
  - Repeat with SHIFT_RIGHT=0: out_data=0x92.
- Gapped strobes: same bits with in_bit_valid every 3rd cycle and in_serial toggling on non-strobe cycles. Required: out_data=0x49, and out_bit_count advances only on strobes.
- Reset mid-frame: in_rst=0 after 3 bits. Required: all outputs 0 and state Idle. A following full frame of 0xA5 yields exactly 0xA5.
- Backpressure: in_ready=0, frames 0x49 then 0xA5. Required: out_data stays 0x49 and out_overrun=1. Then in_clear=1 gives out_overrun=0, and in_ready=1 consumes 0x49 so out_valid drops to 0.
- Simultaneous consume/complete: 0x49 held with out_valid=1, and in_ready=1 in the same edge the 0xA5 frame completes. Required: out_data=0xA5, out_valid stays 1, out_overrun=0.
- Parity (SIPO_RX_CTRL_PARITY_EN defined):
  - Data 0x49 (three 1s) with parity bit 1: out_parity_err=0.
  - Same data with parity bit 0: out_parity_err=1.
  - Required in both cases: out_valid asserts one cycle after the 9th strobe.
